// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared definitions for the VGA raster path (vga_timing and img_generator):
//   640x480@60 Hz timing defaults, counter width, RGB bit layout and a small
//   window-compare helper.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // Width of the x/y raster counters.
    localparam int unsigned CNT_W = 12;

    // Visible frame size, also used by img_generator for its drawing bounds.
    localparam int unsigned FRAME_WIDTH  = 640;
    localparam int unsigned FRAME_HEIGHT = 480;

    // Default 640x480@60 Hz porch/sync lengths (clocks / lines).
    localparam int unsigned H_FRONT_DEF = 16;
    localparam int unsigned H_SYNC_DEF  = 96;
    localparam int unsigned H_BACK_DEF  = 48;
    localparam int unsigned V_FRONT_DEF = 10;
    localparam int unsigned V_SYNC_DEF  = 2;
    localparam int unsigned V_BACK_DEF  = 33;

    // Colour word layout: [2]=R [1]=G [0]=B.
    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    localparam rgb_t RGB_BLACK = '0;

    // True when lo <= cnt < lo+len.
    function automatic logic in_window(input logic [CNT_W-1:0] cnt,
                                       input int unsigned       lo,
                                       input int unsigned       len);
        return (32'(cnt) >= lo) && (32'(cnt) < lo + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   Wrapping up-counter for one raster axis. Advances by one on each clock
//   where en is high and returns to zero after TOTAL-1.
// Ports
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (count -> 0)
//   en     in   advance enable
//   count  out  current count, 0..TOTAL-1
//   wrap   out  high while en is set and count is TOTAL-1 (next edge wraps)
// -----------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int unsigned TOTAL = 800,
    parameter int          W     = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] count,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every output of an always_comb gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        count_d = count_q;
        wrap    = en && (count_q == LAST);
        if (en) begin
            count_d = wrap ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/vga_timing.sv
// -----------------------------------------------------------------------------
// vga_timing
//   640x480@60 Hz VGA raster timing generator, upstream of img_generator.
//   Presents the raster position (x,y) to img_generator, samples its colour,
//   blanks it outside the visible area and registers it together with HS/VS,
//   so all three pins describe the same pixel one clock later.
// Ports
//   CLOCK_25      in   25 MHz pixel clock
//   RESET_N       in   asynchronous active-low reset
//   x, y          out  current pixel column / line (combinational from counters)
//   color         in   img_generator colour for current x,y ([2]=R [1]=G [0]=B)
//   video_active  out  x,y inside the visible area
//   line_tick     out  1-clock strobe on the last pixel of each line
//   frame_tick    out  1-clock strobe on the last pixel of each frame
//   VGA_HS/VGA_VS out  registered sync outputs, active level SYNC_POL
//   VGA_RGB       out  registered, blanked colour
// -----------------------------------------------------------------------------
module vga_timing
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = FRAME_WIDTH,
    parameter int unsigned H_FRONT   = H_FRONT_DEF,
    parameter int unsigned H_SYNC    = H_SYNC_DEF,
    parameter int unsigned H_BACK    = H_BACK_DEF,
    parameter int unsigned V_VISIBLE = FRAME_HEIGHT,
    parameter int unsigned V_FRONT   = V_FRONT_DEF,
    parameter int unsigned V_SYNC    = V_SYNC_DEF,
    parameter int unsigned V_BACK    = V_BACK_DEF,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic             CLOCK_25,
    input  logic             RESET_N,
    output logic [CNT_W-1:0] x,
    output logic [CNT_W-1:0] y,
    input  logic [2:0]       color,
    output logic             video_active,
    output logic             line_tick,
    output logic             frame_tick,
    output logic             VGA_HS,
    output logic             VGA_VS,
    output logic [2:0]       VGA_RGB
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    logic hs_d,  hs_q;
    logic vs_d,  vs_q;
    rgb_t rgb_d, rgb_q;

    vga_axis_counter #(.TOTAL(H_TOTAL), .W(CNT_W)) u_h_cnt (
        .clk   (CLOCK_25),
        .rst_n (RESET_N),
        .en    (1'b1),
        .count (h_cnt),
        .wrap  (h_wrap)
    );

    // The line counter only moves on the last pixel of a line, so both
    // counters wrap on the same edge at the end of a frame.
    vga_axis_counter #(.TOTAL(V_TOTAL), .W(CNT_W)) u_v_cnt (
        .clk   (CLOCK_25),
        .rst_n (RESET_N),
        .en    (h_wrap),
        .count (v_cnt),
        .wrap  (v_wrap)
    );

    always_comb begin
        x            = h_cnt;
        y            = v_cnt;
        video_active = (32'(h_cnt) < H_VISIBLE) && (32'(v_cnt) < V_VISIBLE);
        line_tick    = h_wrap;
        frame_tick   = v_wrap;   // v_wrap already implies h_wrap

        hs_d  = in_window(h_cnt, H_VISIBLE + H_FRONT, H_SYNC) ? SYNC_POL : ~SYNC_POL;
        vs_d  = in_window(v_cnt, V_VISIBLE + V_FRONT, V_SYNC) ? SYNC_POL : ~SYNC_POL;
        rgb_d = video_active ? rgb_t'(color) : RGB_BLACK;
    end

    // Output pipeline stage: sync and colour registered together so they
    // stay aligned to the same pixel at the connector.
    always_ff @(posedge CLOCK_25 or negedge RESET_N) begin
        if (!RESET_N) begin
            hs_q  <= ~SYNC_POL;
            vs_q  <= ~SYNC_POL;
            rgb_q <= RGB_BLACK;
        end else begin
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            rgb_q <= rgb_d;
        end
    end

    assign VGA_HS  = hs_q;
    assign VGA_VS  = vs_q;
    assign VGA_RGB = rgb_q;

endmodule
